id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with load-use hazard detection, sitting directly downstream of the register file. Each rising edge it captures the decoded instruction, both register-file read operands and the control bundle for the execute stage. It inserts a one-cycle bubble on a load-use hazard and squashes the captured instruction on a taken-branch flush. A write-through bypass covers the case where writeback targets a source register in the same cycle. Saturating stall and flush counters are kept for performance analysis.

## Interface
- XLEN, 64, datapath width
- REG_AW, 6, register index width; matches register-file rs1/rs2/rd ports, MSB always 0 for 32 registers
- CNT_W, 32, width of performance counters
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  instruction address
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_AW  source and destination indices
- id_rdata1, id_rdata2  in  XLEN  register-file read_data_1 / read_data_2
- id_ctrl  in  8  control bundle {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
- ex_flush  in  1  taken branch resolved in EX; squash the instruction entering EX
- wb_reg_write  in  1  writeback enable, the same signal as the register-file RegWrite
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback value
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX-stage instruction valid
- ex_pc, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices, kept for the forwarding unit
- ex_rdata1, ex_rdata2  out  XLEN  registered operands, after bypass
- ex_ctrl  out  8  registered control bundle
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Hazard: hazard = ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall_id = hazard & ~ex_flush. A flush overrides a stall.
- On each rising edge, exactly one of three actions applies, in this priority order:
  - ex_flush: insert a bubble. ex_valid=0, ex_ctrl=0; the other data registers may be left unchanged.
  - hazard: insert a bubble, as above. The ID instruction is re-presented next cycle because stall_id held IF/ID.
  - otherwise: capture all id_* fields. ex_valid=id_valid. ex_ctrl=id_valid ? id_ctrl : 0.
- Bypass at capture: ex_rdata1 = (wb_reg_write & wb_rd != 0 & wb_rd == id_rs1) ? wb_data : id_rdata1. The same rule applies to rdata2 with id_rs2.
- Register x0 is never bypassed, and a load with rd=0 never causes a stall.
- stall_count increments on every edge where stall_id=1. flush_count increments on every edge where ex_flush=1. Both saturate at 2^CNT_W-1.

## Timing
- Latency is one cycle, ID to EX.
- stall_id is valid in the same cycle as its inputs; there is no registered path from stall_id to itself.
- A load-use stall lasts exactly one cycle. After the bubble, ex_ctrl.mem_read=0, so the hazard term drops on its own.
- Back-to-back loads to the same rd each produce their own single-cycle stall.
- Reset is asynchronous: every output register goes to 0 (ex_valid=0, ex_ctrl=0, all data 0, both counters 0). Because ex_valid=0, stall_id=0 during and immediately after reset.
- Reset asserted mid-stall: the bubble is dropped. The first edge after reset release captures ID normally.
- ex_flush and hazard in the same cycle: one bubble, stall_id=0, flush_count increments, stall_count does not.

## Structure
- Shared package (riscv_pkg): XLEN, REG_AW, the ctrl-bundle field offsets and width (CTRL_W=8), and the named bit positions.
- The bypass mux and the hazard compare stay inline.
- One natural sub-module, sat_counter (parameter W; ports inc, clk, reset, count), instantiated twice.

## Test plan
- Reset: assert reset mid-cycle with ex_valid=1 -> all outputs read 0 immediately, without waiting for a clock edge.
- Load-use: EX holds ld x5 (mem_read=1, rd=5) while ID holds add x6,x5,x7 -> stall_id=1 for one cycle; next edge ex_valid=0 and stall_count=1; the following edge captures the add.
- x0 load: EX holds ld x0 while ID uses rs1=0 -> stall_id=0 and the instruction is captured normally.
- Flush over stall: hazard present and ex_flush=1 -> stall_id=0, bubble inserted, flush_count=1, stall_count unchanged.
- Bypass: id_rdata1=0x11, wb_reg_write=1, wb_rd=id_rs1=3, wb_data=0xABCD -> ex_rdata1=0xABCD. With wb_rd=0, ex_rdata1=0x11.
- Saturation: CNT_W=4, force 20 stalls -> stall_count holds at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared datapath widths and control-bundle bit positions for
//               the decode/execute pipeline boundary.
//               Control bundle layout, MSB first:
//               {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//                branch, alu_op[1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 6;
  localparam int CTRL_W = 8;

  // Named bit positions inside the control bundle
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_MSB = 1;
  localparam int CTRL_ALU_OP_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments by one on each rising edge where
//               inc is high and sticks at its all-ones value.
// Ports       : clk   - clock
//               reset - asynchronous active-high clear
//               inc   - count this edge
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register. Captures the decoded instruction,
//               both register-file operands (with write-through bypass from
//               writeback) and the control bundle. Inserts a one-cycle bubble
//               on a load-use hazard and squashes on a taken-branch flush.
//               Keeps saturating stall and flush event counters.
// Ports       : clk, reset            - clock, async active-high reset
//               id_*                  - decode-stage instruction and operands
//               ex_flush              - taken branch in EX, squash entry
//               wb_reg_write/rd/data  - writeback port for bypass
//               stall_id              - hold PC and IF/ID (combinational)
//               ex_*                  - registered execute-stage copies
//               stall_count/flush_count - saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic              ex_valid_q,  ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,     ex_pc_d;
  logic [XLEN-1:0]   ex_imm_q,    ex_imm_d;
  logic [REG_AW-1:0] ex_rs1_q,    ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,    ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
  logic [XLEN-1:0]   ex_rdata1_q, ex_rdata1_d;
  logic [XLEN-1:0]   ex_rdata2_q, ex_rdata2_d;
  logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;

  logic hazard;
  logic bypass1;
  logic bypass2;

  // Load in EX whose destination is read by the instruction in ID.
  // A load to x0 never stalls since x0 is never really written.
  assign hazard = ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] & (ex_rd_q != '0) & id_valid &
                  ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  // A flush squashes the ID instruction anyway, so holding IF/ID is pointless.
  assign stall_id = hazard & ~ex_flush;

  // Register file reads the old value while writeback targets the same
  // register this cycle; substitute the value being written.
  assign bypass1 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
  assign bypass2 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_imm_d    = ex_imm_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_rd_d     = ex_rd_q;
    ex_rdata1_d = ex_rdata1_q;
    ex_rdata2_d = ex_rdata2_q;
    ex_ctrl_d   = ex_ctrl_q;
    if (ex_flush || hazard) begin
      // Bubble: only valid and ctrl matter, data fields are don't-care.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else begin
      ex_valid_d  = id_valid;
      ex_pc_d     = id_pc;
      ex_imm_d    = id_imm;
      ex_rs1_d    = id_rs1;
      ex_rs2_d    = id_rs2;
      ex_rd_d     = id_rd;
      ex_rdata1_d = bypass1 ? wb_data : id_rdata1;
      ex_rdata2_d = bypass2 ? wb_data : id_rdata2;
      ex_ctrl_d   = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_imm_q    <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_ctrl_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_imm_q    <= ex_imm_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      ex_rdata1_q <= ex_rdata1_d;
      ex_rdata2_q <= ex_rdata2_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_pc     = ex_pc_q;
  assign ex_imm    = ex_imm_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rdata1 = ex_rdata1_q;
  assign ex_rdata2 = ex_rdata2_q;
  assign ex_ctrl   = ex_ctrl_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_id),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_flush),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage (CNT_W = 4 so
//               counter saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int XLEN   = 64;
  localparam int REG_AW = 6;
  localparam int CNT_W  = 4;

  localparam logic [7:0] C_LD  = 8'hD8; // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [7:0] C_ADD = 8'h82; // reg_write, alu_op=10

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_imm, id_rdata1, id_rdata2, wb_data;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [7:0]        id_ctrl;
  logic              ex_flush, wb_reg_write;
  logic              stall_id, ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rdata1, ex_rdata2;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [7:0]        ex_ctrl;
  logic [CNT_W-1:0]  stall_count, flush_count;

  int vectors     = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_ctrl(id_ctrl), .ex_flush(ex_flush),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_ctrl(ex_ctrl), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                          input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                          input logic [REG_AW-1:0] rd, input logic [7:0] ctrl);
    id_valid  = v;
    id_pc     = pc;
    id_imm    = pc + 64'h100;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_rdata1 = {58'd0, rs1} + 64'h1000;
    id_rdata2 = {58'd0, rs2} + 64'h2000;
    id_ctrl   = ctrl;
    #1;
  endtask

  task automatic test_reset();
    drive_id(1'b1, 64'h40, 6'd1, 6'd2, 6'd3, C_ADD);
    step();
    vectors++;
    if ({ex_valid, ex_rd, ex_ctrl, ex_pc} !== {1'b1, 6'd3, C_ADD, 64'h40}) begin
      miscompares++;
      $display("FAIL pre_reset_capture: got v=%0b rd=%0d ctrl=%h pc=%h, want 1/3/82/40",
               ex_valid, ex_rd, ex_ctrl, ex_pc);
    end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({stall_id, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2,
         ex_ctrl, stall_count, flush_count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: outputs not zero, valid=%0b pc=%h imm=%h rd1=%h ctrl=%h",
               ex_valid, ex_pc, ex_imm, ex_rdata1, ex_ctrl);
    end
    #1 reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 64'h80, 6'd2, 6'd0, 6'd5, C_LD);   // ld x5, 0(x2)
    step();
    drive_id(1'b1, 64'h84, 6'd5, 6'd7, 6'd6, C_ADD);  // add x6, x5, x7
    vectors++;
    if (stall_id !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_stall: stall_id=%0b want 1", stall_id);
    end
    step();
    exp_stall++;
    vectors++;
    if ({ex_valid, ex_ctrl, stall_count, stall_id} !== {1'b0, 8'h00, exp_stall, 1'b0}) begin
      miscompares++;
      $display("FAIL load_use_bubble: v=%0b ctrl=%h cnt=%0d stall=%0b want 0/00/%0d/0",
               ex_valid, ex_ctrl, stall_count, stall_id, exp_stall);
    end
    step();
    vectors++;
    if ({ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_rdata1, stall_count} !==
        {1'b1, 64'h84, 6'd5, 6'd7, 6'd6, C_ADD, 64'h1005, exp_stall}) begin
      miscompares++;
      $display("FAIL load_use_capture: v=%0b pc=%h rd=%0d ctrl=%h rd1=%h cnt=%0d",
               ex_valid, ex_pc, ex_rd, ex_ctrl, ex_rdata1, stall_count);
    end
    // Hazard through rs2 only
    drive_id(1'b1, 64'h88, 6'd1, 6'd0, 6'd9, C_LD);   // ld x9
    step();
    drive_id(1'b1, 64'h8C, 6'd4, 6'd9, 6'd8, C_ADD);  // add x8, x4, x9
    vectors++;
    if (stall_id !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_rs2: stall_id=%0b want 1", stall_id);
    end
    step();
    exp_stall++;
    step();
    vectors++;
    if ({ex_valid, ex_rd, stall_count} !== {1'b1, 6'd8, exp_stall}) begin
      miscompares++;
      $display("FAIL load_use_rs2_capture: v=%0b rd=%0d cnt=%0d want 1/8/%0d",
               ex_valid, ex_rd, stall_count, exp_stall);
    end
  endtask

  task automatic test_x0_load();
    drive_id(1'b1, 64'h90, 6'd2, 6'd0, 6'd0, C_LD);   // ld x0
    step();
    drive_id(1'b1, 64'h94, 6'd0, 6'd0, 6'd6, C_ADD);  // uses x0
    vectors++;
    if (stall_id !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_load_stall: stall_id=%0b want 0", stall_id);
    end
    step();
    vectors++;
    if ({ex_valid, ex_pc, ex_ctrl, stall_count} !== {1'b1, 64'h94, C_ADD, exp_stall}) begin
      miscompares++;
      $display("FAIL x0_load_capture: v=%0b pc=%h ctrl=%h cnt=%0d", ex_valid, ex_pc,
               ex_ctrl, stall_count);
    end
  endtask

  task automatic test_flush_over_stall();
    drive_id(1'b1, 64'hA0, 6'd2, 6'd0, 6'd5, C_LD);
    step();
    drive_id(1'b1, 64'hA4, 6'd5, 6'd5, 6'd6, C_ADD);
    ex_flush = 1'b1;
    #1;
    vectors++;
    if (stall_id !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_over_stall: stall_id=%0b want 0", stall_id);
    end
    step();
    ex_flush = 1'b0;
    exp_flush++;
    vectors++;
    if ({ex_valid, ex_ctrl, flush_count, stall_count} !== {1'b0, 8'h00, exp_flush, exp_stall}) begin
      miscompares++;
      $display("FAIL flush_bubble: v=%0b ctrl=%h fcnt=%0d scnt=%0d want 0/00/%0d/%0d",
               ex_valid, ex_ctrl, flush_count, stall_count, exp_flush, exp_stall);
    end
  endtask

  task automatic test_bypass();
    drive_id(1'b1, 64'hB0, 6'd3, 6'd4, 6'd10, C_ADD);
    id_rdata1 = 64'h11;
    id_rdata2 = 64'h22;
    wb_reg_write = 1'b1;
    wb_rd = 6'd3;
    wb_data = 64'hABCD;
    step();
    vectors++;
    if ({ex_rdata1, ex_rdata2} !== {64'hABCD, 64'h22}) begin
      miscompares++;
      $display("FAIL bypass_rs1: rd1=%h rd2=%h want abcd/22", ex_rdata1, ex_rdata2);
    end
    wb_rd = 6'd4;
    step();
    vectors++;
    if ({ex_rdata1, ex_rdata2} !== {64'h11, 64'hABCD}) begin
      miscompares++;
      $display("FAIL bypass_rs2: rd1=%h rd2=%h want 11/abcd", ex_rdata1, ex_rdata2);
    end
    id_rs1 = 6'd0;
    wb_rd  = 6'd0;
    step();
    vectors++;
    if (ex_rdata1 !== 64'h11) begin
      miscompares++;
      $display("FAIL bypass_x0: rd1=%h want 11", ex_rdata1);
    end
    id_rs1 = 6'd3;
    wb_rd  = 6'd3;
    wb_reg_write = 1'b0;
    step();
    vectors++;
    if (ex_rdata1 !== 64'h11) begin
      miscompares++;
      $display("FAIL bypass_no_we: rd1=%h want 11", ex_rdata1);
    end
    wb_rd = 6'd0;
    wb_data = '0;
  endtask

  task automatic test_back_to_back();
    drive_id(1'b1, 64'hC0, 6'd5, 6'd0, 6'd5, C_LD);   // ld x5, 0(x5) repeated
    step();                                           // first load enters EX
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (stall_id !== 1'b1) begin
        miscompares++;
        $display("FAIL back_to_back_stall%0d: stall_id=%0b want 1", k, stall_id);
      end
      step();
      exp_stall++;
      vectors++;
      if ({ex_valid, stall_id} !== 2'b00) begin
        miscompares++;
        $display("FAIL back_to_back_bubble%0d: v=%0b stall=%0b want 0/0", k, ex_valid, stall_id);
      end
      step();                                         // load re-captured
    end
    vectors++;
    if ({ex_valid, ex_ctrl, stall_count} !== {1'b1, C_LD, exp_stall}) begin
      miscompares++;
      $display("FAIL back_to_back_count: v=%0b ctrl=%h cnt=%0d want 1/d8/%0d",
               ex_valid, ex_ctrl, stall_count, exp_stall);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 64'hD4, 6'd5, 6'd1, 6'd6, C_ADD);  // EX holds ld x5 from before
    vectors++;
    if (stall_id !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_stall_pre: stall_id=%0b want 1", stall_id);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({stall_id, ex_valid, stall_count, flush_count} !== '0) begin
      miscompares++;
      $display("FAIL mid_stall_reset: stall=%0b v=%0b scnt=%0d fcnt=%0d want all 0",
               stall_id, ex_valid, stall_count, flush_count);
    end
    #1 reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    step();
    vectors++;
    if ({ex_valid, ex_pc, ex_rd, ex_ctrl, stall_count} !== {1'b1, 64'hD4, 6'd6, C_ADD, 4'd0}) begin
      miscompares++;
      $display("FAIL mid_stall_capture: v=%0b pc=%h rd=%0d ctrl=%h cnt=%0d",
               ex_valid, ex_pc, ex_rd, ex_ctrl, stall_count);
    end
  endtask

  task automatic test_saturation();
    drive_id(1'b1, 64'hE0, 6'd5, 6'd0, 6'd5, C_LD);
    step();
    for (int k = 0; k < 20; k++) begin
      step();                                         // stall edge
      step();                                         // re-capture edge
    end
    vectors++;
    if ({stall_count, stall_id} !== {4'd15, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_saturate: cnt=%0d stall=%0b want 15/1", stall_count, stall_id);
    end
    ex_flush = 1'b1;
    repeat (20) step();
    ex_flush = 1'b0;
    vectors++;
    if ({flush_count, stall_count} !== {4'd15, 4'd15}) begin
      miscompares++;
      $display("FAIL flush_saturate: fcnt=%0d scnt=%0d want 15/15", flush_count, stall_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    ex_flush = 1'b0;
    wb_reg_write = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    drive_id(1'b0, '0, '0, '0, '0, '0);
    repeat (2) step();
    reset = 1'b0;
    vectors++;
    if ({ex_valid, ex_ctrl, stall_id, stall_count, flush_count} !== '0) begin
      miscompares++;
      $display("FAIL initial_reset: v=%0b ctrl=%h stall=%0b scnt=%0d fcnt=%0d",
               ex_valid, ex_ctrl, stall_id, stall_count, flush_count);
    end
    test_reset();
    test_load_use();
    test_x0_load();
    test_flush_over_stall();
    test_bypass();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
